fetch_unit: RTL

//  Instruction fetch stage directly upstream of the control decoder.
//  - Holds the program counter and issues one request per instruction to the instruction memory.
//  - Captures each returned 8-bit word into an instruction register and presents it to the decoder with a valid/ready handshake.
//  - Redirects the PC on a jump request from execute.

---
 rtl/fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the control decoder. Holds the program
//   counter, issues one instruction-memory request per instruction, captures
//   the returned word into the instruction register and hands it downstream
//   with a valid/ready handshake. A jump from execute redirects the PC from
//   any state and discards whatever fetch or issue is in flight.
//
//   Sequencing:
//     ST_IDLE  : one-cycle post-reset state so imem_req first rises on the
//                clock edge after rst deasserts.
//     ST_FETCH : imem_req=1 with imem_addr=pc until imem_ack arrives.
//     ST_ISSUE : instr_valid=1, instr/instr_pc frozen until instr_ready.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,

    // Instruction memory
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,

    // Decoder side
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,

    // Redirect from execute
    input  logic               jump_valid,
    input  logic [PC_W-1:0]    jump_target,

    output logic [PC_W-1:0]    pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // A returned word is only accepted while a request is outstanding and no
    // redirect is pending; an ack in ISSUE/IDLE or alongside a jump is dropped.
    logic capture;

    assign capture   = (state == ST_FETCH) && imem_ack && !jump_valid;

    // The fetch address is the PC itself, so it is stable for the whole wait.
    assign imem_addr = pc;

    // State register; async reset parks the FSM in IDLE so imem_req drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples pre-edge values regardless of block order.
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; a jump overrides every transition.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        unique case (state)
            ST_IDLE: begin
                state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nx = ST_FETCH;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (jump_valid) begin
            state_nx = ST_FETCH;
        end
    end

    // PC and instruction register; redirect wins over a same-cycle capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
        end else if (jump_valid) begin
            pc <= jump_target;
        end else if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            // Wraps modulo 2^PC_W with no overflow indication.
            pc       <= pc + PC_W'(1);
        end
    end

endmodule
